// File: rtl/dm_arbiter.sv
// Two-port arbiter in front of the 512x32 data memory: round-robin between the sort engine (E)
// and the debug loader (D), with an engine lock and a bounded debug-starvation escape.
module dm_arbiter #(
    parameter int unsigned AW       = 9,
    parameter int unsigned DW       = 32,
    parameter int unsigned LOCK_MAX = 1024
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          e_req,
    input  logic          e_we,
    input  logic [AW-1:0] e_addr,
    input  logic [DW-1:0] e_wdata,
    input  logic          e_lock,
    output logic          e_gnt,
    output logic          e_ack,
    output logic [DW-1:0] e_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_gnt,
    output logic          d_ack,
    output logic [DW-1:0] d_rdata,
    output logic [AW-1:0] mem_a,
    output logic [DW-1:0] mem_d,
    output logic          mem_we,
    input  logic [DW-1:0] mem_spo,
    output logic [1:0]    owner,
    input  logic          cnt_clr,
    output logic [15:0]   e_wait,
    output logic [15:0]   d_wait,
    output logic          lock_timeout
);

    localparam int unsigned LkW = (LOCK_MAX > 1) ? $clog2(LOCK_MAX) : 1;
    localparam logic [LkW-1:0] LkLast = LkW'((LOCK_MAX == 0) ? 0 : LOCK_MAX - 1);

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StEng  = 2'b01,
        StDbg  = 2'b10,
        StLock = 2'b11
    } owner_e;

    owner_e         owner_q, owner_d;
    logic           last_d_q;  // 1: D was granted most recently
    logic [LkW-1:0] lk_cnt_q, lk_cnt_d;
    logic           locked, forced;

    always_comb begin
        locked   = (owner_q == StLock) && e_lock;
        forced   = 1'b0;
        e_gnt    = 1'b0;
        d_gnt    = 1'b0;
        owner_d  = StIdle;
        lk_cnt_d = '0;
        // rstn is active-high: no grant may reach the memory during reset
        if (!rstn) begin
            if (locked) begin
                forced = (LOCK_MAX != 0) && d_req && (lk_cnt_q == LkLast);
                d_gnt  = forced;
                e_gnt  = e_req && !forced;
            end else if (e_req && d_req) begin
                e_gnt = last_d_q;
                d_gnt = !last_d_q;
            end else begin
                e_gnt = e_req;
                d_gnt = d_req;
            end
        end
        if (e_gnt) begin
            owner_d = e_lock ? StLock : StEng;
        end else if (d_gnt) begin
            owner_d = forced ? StLock : StDbg;
        end else if (locked) begin
            owner_d = StLock;
        end
        if (locked && d_req && !d_gnt) begin
            lk_cnt_d = lk_cnt_q + 1'b1;
        end
    end

    always_comb begin
        mem_a  = '0;
        mem_d  = '0;
        mem_we = 1'b0;
        if (e_gnt) begin
            mem_a  = e_addr;
            mem_d  = e_wdata;
            mem_we = e_we;
        end else if (d_gnt) begin
            mem_a  = d_addr;
            mem_d  = d_wdata;
            mem_we = d_we;
        end
    end

    assign owner = owner_q;

    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            owner_q      <= StIdle;
            last_d_q     <= 1'b1;
            lk_cnt_q     <= '0;
            e_ack        <= 1'b0;
            d_ack        <= 1'b0;
            e_rdata      <= '0;
            d_rdata      <= '0;
            e_wait       <= '0;
            d_wait       <= '0;
            lock_timeout <= 1'b0;
        end else begin
            owner_q  <= owner_d;
            lk_cnt_q <= lk_cnt_d;
            e_ack    <= e_gnt;
            d_ack    <= d_gnt;
            if (e_gnt) begin
                last_d_q <= 1'b0;
            end else if (d_gnt) begin
                last_d_q <= 1'b1;
            end
            if (e_gnt && !e_we) begin
                e_rdata <= mem_spo;
            end
            if (d_gnt && !d_we) begin
                d_rdata <= mem_spo;
            end
            if (forced) begin
                lock_timeout <= 1'b1;
            end
            if (cnt_clr) begin
                e_wait <= '0;
            end else if (e_req && !e_gnt && e_wait != 16'hFFFF) begin
                e_wait <= e_wait + 16'd1;
            end
            if (cnt_clr) begin
                d_wait <= '0;
            end else if (d_req && !d_gnt && d_wait != 16'hFFFF) begin
                d_wait <= d_wait + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_dm_arbiter.sv
// Directed bench for dm_arbiter: one instance with LOCK_MAX=8 on a memory model, and one with the
// lock escape disabled sharing the same stimulus for the starvation/saturation case.
module tb_dm_arbiter;

    logic        clk = 1'b0;
    logic        rstn = 1'b1;
    logic        e_req = 0, e_we = 0, e_lock = 0, d_req = 0, d_we = 0, cnt_clr = 0;
    logic [8:0]  e_addr = '0, d_addr = '0;
    logic [31:0] e_wdata = '0, d_wdata = '0;

    logic        e_gnt, e_ack, d_gnt, d_ack, mem_we, lock_timeout;
    logic [31:0] e_rdata, d_rdata, mem_d, mem_spo;
    logic [8:0]  mem_a;
    logic [1:0]  owner;
    logic [15:0] e_wait, d_wait;

    logic        nf_e_gnt, nf_e_ack, nf_d_gnt, nf_d_ack, nf_mem_we, nf_lock_timeout;
    logic [31:0] nf_e_rdata, nf_d_rdata, nf_mem_d;
    logic [31:0] nf_spo = '0;
    logic [8:0]  nf_mem_a;
    logic [1:0]  nf_owner;
    logic [15:0] nf_e_wait, nf_d_wait;

    logic [31:0] mem [512];
    logic        tb_we = 1'b0;
    logic [8:0]  tb_a = '0;
    logic [31:0] tb_d = '0;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    assign mem_spo = mem[mem_a];
    always @(posedge clk) begin
        if (mem_we) mem[mem_a] <= mem_d;
        else if (tb_we) mem[tb_a] <= tb_d;
    end

    dm_arbiter #(.AW(9), .DW(32), .LOCK_MAX(8)) u_dut (
        .clk(clk), .rstn(rstn),
        .e_req(e_req), .e_we(e_we), .e_addr(e_addr), .e_wdata(e_wdata), .e_lock(e_lock),
        .e_gnt(e_gnt), .e_ack(e_ack), .e_rdata(e_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_ack(d_ack), .d_rdata(d_rdata),
        .mem_a(mem_a), .mem_d(mem_d), .mem_we(mem_we), .mem_spo(mem_spo),
        .owner(owner), .cnt_clr(cnt_clr), .e_wait(e_wait), .d_wait(d_wait),
        .lock_timeout(lock_timeout)
    );

    dm_arbiter #(.AW(9), .DW(32), .LOCK_MAX(0)) u_nf (
        .clk(clk), .rstn(rstn),
        .e_req(e_req), .e_we(e_we), .e_addr(e_addr), .e_wdata(e_wdata), .e_lock(e_lock),
        .e_gnt(nf_e_gnt), .e_ack(nf_e_ack), .e_rdata(nf_e_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(nf_d_gnt), .d_ack(nf_d_ack), .d_rdata(nf_d_rdata),
        .mem_a(nf_mem_a), .mem_d(nf_mem_d), .mem_we(nf_mem_we), .mem_spo(nf_spo),
        .owner(nf_owner), .cnt_clr(cnt_clr), .e_wait(nf_e_wait), .d_wait(nf_d_wait),
        .lock_timeout(nf_lock_timeout)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        e_req = 0; e_we = 0; e_lock = 0; d_req = 0; d_we = 0; cnt_clr = 0;
        rstn = 1'b1;
        tick();
        rstn = 1'b0;
    endtask

    task automatic test_reset;
        // Engine requests a write throughout reset; nothing may reach the memory.
        e_req = 1; e_we = 1; e_addr = 9'd5; e_wdata = 32'hBAD0BAD0;
        tb_we = 1; tb_a = 9'd5; tb_d = 32'h1234;
        tick();
        tb_a = 9'd9; tb_d = 32'h99;
        #1;
        n_cmp++; if (e_gnt !== 1'b0) begin n_bad++; $display("FAIL reset_e_gnt: got %b want 0", e_gnt); end
        n_cmp++; if (mem_we !== 1'b0) begin n_bad++; $display("FAIL reset_mem_we: got %b want 0", mem_we); end
        tick();
        tb_we = 0;
        n_cmp++; if (owner !== 2'b00) begin n_bad++; $display("FAIL reset_owner: got %b want 00", owner); end
        n_cmp++; if ({e_ack, d_ack, lock_timeout} !== 3'b000) begin n_bad++; $display("FAIL reset_flags: got %b want 000", {e_ack, d_ack, lock_timeout}); end
        n_cmp++; if ({e_rdata, d_rdata} !== 64'h0) begin n_bad++; $display("FAIL reset_rdata: got %h want 0", {e_rdata, d_rdata}); end
        n_cmp++; if ({e_wait, d_wait} !== 32'h0) begin n_bad++; $display("FAIL reset_wait: got %h want 0", {e_wait, d_wait}); end
        n_cmp++; if (mem[5] !== 32'h1234) begin n_bad++; $display("FAIL reset_no_write: got %h want 00001234", mem[5]); end
        e_req = 0; e_we = 0;
        rstn = 0;
    endtask

    task automatic test_read;
        e_req = 1; e_we = 0; e_addr = 9'd5;
        #2;
        n_cmp++; if ({e_gnt, d_gnt} !== 2'b10) begin n_bad++; $display("FAIL read_gnt: got %b want 10", {e_gnt, d_gnt}); end
        n_cmp++; if (mem_a !== 9'd5) begin n_bad++; $display("FAIL read_mem_a: got %0d want 5", mem_a); end
        tick();
        e_req = 0;
        n_cmp++; if (e_ack !== 1'b1) begin n_bad++; $display("FAIL read_ack: got %b want 1", e_ack); end
        n_cmp++; if (e_rdata !== 32'h1234) begin n_bad++; $display("FAIL read_rdata: got %h want 00001234", e_rdata); end
        n_cmp++; if (owner !== 2'b01) begin n_bad++; $display("FAIL read_owner: got %b want 01", owner); end
        tick();
        n_cmp++; if ({e_ack, owner} !== 3'b000) begin n_bad++; $display("FAIL read_idle: got %b want 000", {e_ack, owner}); end
    endtask

    task automatic test_round_robin;
        do_reset();
        e_req = 1; e_we = 0; e_addr = 9'd5;
        d_req = 1; d_we = 0; d_addr = 9'd5;
        for (int c = 1; c <= 6; c++) begin
            logic e_exp;
            e_exp = (c % 2) == 1;
            #2;
            n_cmp++; if ({e_gnt, d_gnt} !== {e_exp, !e_exp}) begin n_bad++; $display("FAIL rr_gnt%0d: got %b want %b", c, {e_gnt, d_gnt}, {e_exp, !e_exp}); end
            tick();
            n_cmp++; if (d_wait !== 16'((c + 1) / 2)) begin n_bad++; $display("FAIL rr_d_wait%0d: got %0d want %0d", c, d_wait, (c + 1) / 2); end
            n_cmp++; if (e_wait !== 16'(c / 2)) begin n_bad++; $display("FAIL rr_e_wait%0d: got %0d want %0d", c, e_wait, c / 2); end
        end
        n_cmp++; if ({owner, d_ack, d_rdata} !== {2'b10, 1'b1, 32'h1234}) begin n_bad++; $display("FAIL rr_end: got %b %b %h want 10 1 00001234", owner, d_ack, d_rdata); end
        e_req = 0; d_req = 0;
    endtask

    task automatic test_lock;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            e_req = 1; e_we = 1; e_lock = 1; e_addr = 9'(i); e_wdata = 32'hA0 + 32'(i);
            #2;
            n_cmp++; if (e_gnt !== 1'b1) begin n_bad++; $display("FAIL lock_wr_gnt%0d: got %b want 1", i, e_gnt); end
            tick();
            n_cmp++; if (owner !== 2'b11) begin n_bad++; $display("FAIL lock_wr_owner%0d: got %b want 11", i, owner); end
        end
        e_req = 0; e_we = 0;
        d_req = 1; d_we = 0; d_addr = 9'd5;
        for (int i = 0; i < 4; i++) begin
            #2;
            n_cmp++; if (d_gnt !== 1'b0) begin n_bad++; $display("FAIL lock_hold_d_gnt%0d: got %b want 0", i, d_gnt); end
            tick();
        end
        n_cmp++; if ({owner, d_wait} !== {2'b11, 16'd4}) begin n_bad++; $display("FAIL lock_hold: got owner %b d_wait %0d want 11 4", owner, d_wait); end
        n_cmp++; if ({mem[0], mem[3]} !== {32'hA0, 32'hA3}) begin n_bad++; $display("FAIL lock_mem: got %h %h want a0 a3", mem[0], mem[3]); end
        n_cmp++; if (lock_timeout !== 1'b0) begin n_bad++; $display("FAIL lock_no_timeout: got %b want 0", lock_timeout); end
        e_lock = 0;
        #2;
        n_cmp++; if (d_gnt !== 1'b1) begin n_bad++; $display("FAIL lock_release_d_gnt: got %b want 1", d_gnt); end
        tick();
        d_req = 0;
        n_cmp++; if ({owner, d_ack, d_rdata} !== {2'b10, 1'b1, 32'h1234}) begin n_bad++; $display("FAIL lock_release: got %b %b %h want 10 1 00001234", owner, d_ack, d_rdata); end
    endtask

    task automatic test_lock_escape;
        int forced_n;
        forced_n = 0;
        do_reset();
        e_req = 1; e_we = 0; e_lock = 1; e_addr = 9'd5;
        d_req = 1; d_we = 0; d_addr = 9'd7;
        // Cycle 1 is the unlocked grant to E; forced D grants then land on 9, 17, 25.
        for (int c = 1; c <= 25; c++) begin
            logic d_exp;
            d_exp = (c >= 9) && (((c - 9) % 8) == 0);
            #2;
            n_cmp++; if ({e_gnt, d_gnt} !== {!d_exp, d_exp}) begin n_bad++; $display("FAIL esc_gnt%0d: got %b want %b", c, {e_gnt, d_gnt}, {!d_exp, d_exp}); end
            if (d_gnt) forced_n++;
            tick();
            n_cmp++; if (owner !== 2'b11) begin n_bad++; $display("FAIL esc_owner%0d: got %b want 11", c, owner); end
            n_cmp++; if (lock_timeout !== (c >= 9)) begin n_bad++; $display("FAIL esc_timeout%0d: got %b want %b", c, lock_timeout, c >= 9); end
        end
        n_cmp++; if (forced_n !== 3) begin n_bad++; $display("FAIL esc_count: got %0d want 3", forced_n); end
        e_req = 0; e_lock = 0; d_req = 0;
    endtask

    task automatic test_top_addr;
        do_reset();
        d_req = 1; d_we = 1; d_addr = 9'd511; d_wdata = 32'hDEADBEEF;
        #2;
        n_cmp++; if ({d_gnt, mem_we, mem_a} !== {1'b1, 1'b1, 9'd511}) begin n_bad++; $display("FAIL top_wr: got %b %b %0d want 1 1 511", d_gnt, mem_we, mem_a); end
        tick();
        d_req = 0; d_we = 0;
        e_req = 1; e_we = 0; e_addr = 9'd511;
        tick();
        e_req = 0;
        n_cmp++; if (e_rdata !== 32'hDEADBEEF) begin n_bad++; $display("FAIL top_rd: got %h want deadbeef", e_rdata); end
        n_cmp++; if (mem[0] !== 32'hA0) begin n_bad++; $display("FAIL top_no_wrap: got %h want 000000a0", mem[0]); end
    endtask

    task automatic test_reset_mid_write;
        e_req = 1; e_we = 1; e_addr = 9'd9; e_wdata = 32'h5555;
        #2;
        n_cmp++; if (e_gnt !== 1'b1) begin n_bad++; $display("FAIL mid_gnt_before: got %b want 1", e_gnt); end
        rstn = 1;
        #1;
        n_cmp++; if ({e_gnt, mem_we} !== 2'b00) begin n_bad++; $display("FAIL mid_gated: got %b want 00", {e_gnt, mem_we}); end
        n_cmp++; if (e_rdata !== 32'h0) begin n_bad++; $display("FAIL mid_rdata: got %h want 0", e_rdata); end
        tick();
        n_cmp++; if (mem[9] !== 32'h99) begin n_bad++; $display("FAIL mid_mem: got %h want 00000099", mem[9]); end
        n_cmp++; if ({e_ack, owner} !== 3'b000) begin n_bad++; $display("FAIL mid_state: got %b want 000", {e_ack, owner}); end
        e_req = 0; e_we = 0;
        rstn = 0;
    endtask

    task automatic test_saturation;
        do_reset();
        e_req = 1; e_we = 0; e_lock = 1; e_addr = 9'd5;
        tick();
        n_cmp++; if (nf_owner !== 2'b11) begin n_bad++; $display("FAIL sat_owner: got %b want 11", nf_owner); end
        e_req = 0;
        d_req = 1; d_we = 0; d_addr = 9'd5;
        repeat (70000) tick();
        n_cmp++; if (nf_d_wait !== 16'hFFFF) begin n_bad++; $display("FAIL sat_d_wait: got %h want ffff", nf_d_wait); end
        n_cmp++; if (nf_d_gnt !== 1'b0) begin n_bad++; $display("FAIL sat_d_gnt: got %b want 0", nf_d_gnt); end
        cnt_clr = 1;
        tick();
        n_cmp++; if (nf_d_wait !== 16'h0) begin n_bad++; $display("FAIL sat_clr: got %h want 0", nf_d_wait); end
        cnt_clr = 0;
        tick();
        n_cmp++; if (nf_d_wait !== 16'h1) begin n_bad++; $display("FAIL sat_restart: got %h want 1", nf_d_wait); end
        d_req = 0; e_lock = 0;
    endtask

    initial begin
        test_reset();
        test_read();
        test_round_robin();
        test_lock();
        test_lock_escape();
        test_top_addr();
        test_reset_mid_write();
        test_saturation();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
